// File: rtl/mem_arbiter_if.sv
// Bus bundle between two requesters (A = instruction fetch, B = data access)
// and the single shared memory port arbitrated by mem_arbiter.
interface mem_arbiter_if;
  logic        a_read;
  logic        a_write;
  logic [3:0]  a_byte_enable;
  logic [31:0] a_address;
  logic [31:0] a_wdata;
  logic [31:0] a_rdata;
  logic        a_resp;

  logic        b_read;
  logic        b_write;
  logic [3:0]  b_byte_enable;
  logic [31:0] b_address;
  logic [31:0] b_wdata;
  logic [31:0] b_rdata;
  logic        b_resp;

  logic        mem_read;
  logic        mem_write;
  logic [3:0]  mem_byte_enable;
  logic [31:0] mem_address;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_resp;

  modport master (
    input  a_read, a_write, a_byte_enable, a_address, a_wdata,
    output a_rdata, a_resp,
    input  b_read, b_write, b_byte_enable, b_address, b_wdata,
    output b_rdata, b_resp,
    output mem_read, mem_write, mem_byte_enable, mem_address, mem_wdata,
    input  mem_rdata, mem_resp
  );

  modport slave (
    output a_read, a_write, a_byte_enable, a_address, a_wdata,
    input  a_rdata, a_resp,
    output b_read, b_write, b_byte_enable, b_address, b_wdata,
    input  b_rdata, b_resp,
    input  mem_read, mem_write, mem_byte_enable, mem_address, mem_wdata,
    output mem_rdata, mem_resp
  );
endinterface

// File: rtl/mem_arbiter.sv
// Two-requester arbiter for one shared memory port; fixed B-over-A priority with a
// starvation guard, or alternating tie-break when MEM_ARBITER_RR_EN is defined.
module mem_arbiter #(
  parameter int STARVE_LIMIT = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  mem_arbiter_if.master bus
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT_A = 2'd1,
    GRANT_B = 2'd2
  } state_e;

  state_e state_q, state_d;
  logic   a_pend;
  logic   b_pend;
  logic   tie_grant_a;

  assign a_pend = bus.a_read | bus.a_write;
  assign b_pend = bus.b_read | bus.b_write;

`ifdef MEM_ARBITER_RR_EN
  // last_b_q remembers who won the previous grant; reset value means "A".
  logic last_b_q, last_b_d;

  assign tie_grant_a = last_b_q;

  always_comb begin
    last_b_d = last_b_q;
    if (state_q == IDLE) begin
      if (state_d == GRANT_A) begin
        last_b_d = 1'b0;
      end else if (state_d == GRANT_B) begin
        last_b_d = 1'b1;
      end else begin
        last_b_d = last_b_q;
      end
    end else begin
      last_b_d = last_b_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_b_q <= 1'b0;
    end else begin
      last_b_q <= last_b_d;
    end
  end
`else
  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);
  logic [3:0] starve_q, starve_d;

  assign tie_grant_a = (starve_q == LIMIT);

  // Counts B wins over a waiting A; A is forced through once it reaches LIMIT.
  always_comb begin
    starve_d = starve_q;
    if (state_q == IDLE) begin
      if (!a_pend || (state_d == GRANT_A)) begin
        starve_d = 4'd0;
      end else if ((state_d == GRANT_B) && (starve_q != LIMIT)) begin
        starve_d = starve_q + 4'd1;
      end else begin
        starve_d = starve_q;
      end
    end else begin
      starve_d = starve_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_q <= 4'd0;
    end else begin
      starve_q <= starve_d;
    end
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // A grant ends on mem_resp or when the owner withdraws its strobes (abort).
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (a_pend && b_pend) begin
          state_d = tie_grant_a ? GRANT_A : GRANT_B;
        end else if (a_pend) begin
          state_d = GRANT_A;
        end else if (b_pend) begin
          state_d = GRANT_B;
        end else begin
          state_d = IDLE;
        end
      end
      GRANT_A: begin
        if (!a_pend || bus.mem_resp) begin
          state_d = IDLE;
        end else begin
          state_d = GRANT_A;
        end
      end
      GRANT_B: begin
        if (!b_pend || bus.mem_resp) begin
          state_d = IDLE;
        end else begin
          state_d = GRANT_B;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.mem_read        = 1'b0;
    bus.mem_write       = 1'b0;
    bus.mem_byte_enable = 4'h0;
    bus.mem_address     = 32'h0;
    bus.mem_wdata       = 32'h0;
    bus.a_resp          = 1'b0;
    bus.b_resp          = 1'b0;
    case (state_q)
      GRANT_A: begin
        bus.mem_read        = bus.a_read;
        bus.mem_write       = bus.a_write;
        bus.mem_byte_enable = bus.a_byte_enable;
        bus.mem_address     = bus.a_address;
        bus.mem_wdata       = bus.a_wdata;
        bus.a_resp          = bus.mem_resp;
      end
      GRANT_B: begin
        bus.mem_read        = bus.b_read;
        bus.mem_write       = bus.b_write;
        bus.mem_byte_enable = bus.b_byte_enable;
        bus.mem_address     = bus.b_address;
        bus.mem_wdata       = bus.b_wdata;
        bus.b_resp          = bus.mem_resp;
      end
      default: begin
        bus.a_resp = 1'b0;
        bus.b_resp = 1'b0;
      end
    endcase
  end

  assign bus.a_rdata = bus.mem_rdata;
  assign bus.b_rdata = bus.mem_rdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter (STARVE_LIMIT=3); expectations
// for the tie-break sequence follow MEM_ARBITER_RR_EN when it is defined.
module tb_mem_arbiter;

  localparam logic [31:0] A_ADDR = 32'h0000_0060;
  localparam logic [31:0] B_ADDR = 32'h0000_0100;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_err;
  logic [7:0] exp_a;

  mem_arbiter_if bus();

  mem_arbiter #(.STARVE_LIMIT(3)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic drop_all();
    bus.a_read = 1'b0;  bus.a_write = 1'b0;  bus.a_byte_enable = 4'h0;
    bus.a_address = 32'h0;  bus.a_wdata = 32'h0;
    bus.b_read = 1'b0;  bus.b_write = 1'b0;  bus.b_byte_enable = 4'h0;
    bus.b_address = 32'h0;  bus.b_wdata = 32'h0;
    bus.mem_resp = 1'b0;  bus.mem_rdata = 32'h0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    n_cmp = 0;
    n_err = 0;
    clk   = 1'b0;
    rst_n = 1'b0;
`ifdef MEM_ARBITER_RR_EN
    exp_a = 8'b1010_1010;
`else
    exp_a = 8'b1000_1000;
`endif
    drop_all();

    // Reset state
    @(negedge clk);
    @(negedge clk);
    check_eq("rst_mem_read", 32'(bus.mem_read), 32'd0);
    check_eq("rst_mem_write", 32'(bus.mem_write), 32'd0);
    check_eq("rst_mem_addr", bus.mem_address, 32'h0);
    check_eq("rst_a_resp", 32'(bus.a_resp), 32'd0);
    check_eq("rst_b_resp", 32'(bus.b_resp), 32'd0);

    // Single A read
    rst_n = 1'b1;
    bus.a_read = 1'b1;  bus.a_address = A_ADDR;  bus.a_byte_enable = 4'hF;
    #1;
    check_eq("a_rd_idle", 32'(bus.mem_read), 32'd0);
    @(negedge clk);
    check_eq("a_rd_strobe", 32'(bus.mem_read), 32'd1);
    check_eq("a_rd_addr", bus.mem_address, A_ADDR);
    bus.mem_resp = 1'b1;  bus.mem_rdata = 32'h0000_0013;
    #1;
    check_eq("a_rd_resp", 32'(bus.a_resp), 32'd1);
    check_eq("a_rd_rdata", bus.a_rdata, 32'h0000_0013);
    check_eq("a_rd_b_resp", 32'(bus.b_resp), 32'd0);
    @(negedge clk);
    check_eq("a_rd_back_idle", 32'(bus.mem_read), 32'd0);
    check_eq("idle_resp_ignored", 32'(bus.a_resp), 32'd0);
    check_eq("b_rdata_follow", bus.b_rdata, 32'h0000_0013);
    drop_all();

    // Simultaneous A read / B write: B first, then A after an IDLE cycle
    @(negedge clk);
    bus.a_read = 1'b1;  bus.a_address = A_ADDR;  bus.a_byte_enable = 4'hF;
    bus.b_write = 1'b1;  bus.b_address = B_ADDR;  bus.b_wdata = 32'hDEAD_BEEF;
    bus.b_byte_enable = 4'hF;
    @(negedge clk);
    check_eq("tie_b_write", 32'(bus.mem_write), 32'd1);
    check_eq("tie_b_read", 32'(bus.mem_read), 32'd0);
    check_eq("tie_b_addr", bus.mem_address, B_ADDR);
    check_eq("tie_b_wdata", bus.mem_wdata, 32'hDEAD_BEEF);
    check_eq("tie_b_be", 32'(bus.mem_byte_enable), 32'hF);
    bus.mem_resp = 1'b1;
    #1;
    check_eq("tie_b_resp", 32'(bus.b_resp), 32'd1);
    check_eq("tie_b_a_resp", 32'(bus.a_resp), 32'd0);
    @(negedge clk);
    bus.b_write = 1'b0;  bus.mem_resp = 1'b0;
    check_eq("tie_gap_idle", 32'(bus.mem_read), 32'd0);
    @(negedge clk);
    check_eq("tie_a_read", 32'(bus.mem_read), 32'd1);
    check_eq("tie_a_addr", bus.mem_address, A_ADDR);
    bus.mem_resp = 1'b1;
    #1;
    check_eq("tie_a_resp", 32'(bus.a_resp), 32'd1);
    @(negedge clk);
    drop_all();

    // Both held continuously with a 1-cycle memory
    @(negedge clk);
    bus.a_read = 1'b1;  bus.a_address = A_ADDR;
    bus.b_read = 1'b1;  bus.b_address = B_ADDR;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check_eq($sformatf("rot%0d_addr", i), bus.mem_address, exp_a[i] ? A_ADDR : B_ADDR);
      check_eq($sformatf("rot%0d_read", i), 32'(bus.mem_read), 32'd1);
      bus.mem_resp = 1'b1;
      #1;
      check_eq($sformatf("rot%0d_a_resp", i), 32'(bus.a_resp), 32'(exp_a[i]));
      check_eq($sformatf("rot%0d_b_resp", i), 32'(bus.b_resp), 32'(!exp_a[i]));
      @(negedge clk);
      bus.mem_resp = 1'b0;
      check_eq($sformatf("rot%0d_idle", i), 32'(bus.mem_read), 32'd0);
    end
    drop_all();

    // Reset pulse in the middle of a B write
    @(negedge clk);
    bus.b_write = 1'b1;  bus.b_address = B_ADDR;  bus.b_wdata = 32'hDEAD_BEEF;
    bus.b_byte_enable = 4'hF;
    @(negedge clk);
    check_eq("rstmid_write", 32'(bus.mem_write), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("rstmid_write_drop", 32'(bus.mem_write), 32'd0);
    check_eq("rstmid_read_drop", 32'(bus.mem_read), 32'd0);
    bus.mem_resp = 1'b1;
    #1;
    check_eq("rstmid_b_resp", 32'(bus.b_resp), 32'd0);
    @(negedge clk);
    bus.b_write = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("rstmid_late_b_resp", 32'(bus.b_resp), 32'd0);
    check_eq("rstmid_late_a_resp", 32'(bus.a_resp), 32'd0);
    check_eq("rstmid_late_write", 32'(bus.mem_write), 32'd0);
    drop_all();

    // A asserts read+write together, then aborts before mem_resp
    @(negedge clk);
    bus.a_read = 1'b1;  bus.a_write = 1'b1;  bus.a_byte_enable = 4'h3;
    bus.a_address = A_ADDR;  bus.a_wdata = 32'h0000_55AA;
    @(negedge clk);
    check_eq("rw_read", 32'(bus.mem_read), 32'd1);
    check_eq("rw_write", 32'(bus.mem_write), 32'd1);
    check_eq("rw_be", 32'(bus.mem_byte_enable), 32'h3);
    check_eq("rw_wdata", bus.mem_wdata, 32'h0000_55AA);
    bus.a_read = 1'b0;  bus.a_write = 1'b0;
    #1;
    check_eq("abort_read_drop", 32'(bus.mem_read), 32'd0);
    check_eq("abort_write_drop", 32'(bus.mem_write), 32'd0);
    @(negedge clk);
    bus.mem_resp = 1'b1;  bus.mem_rdata = 32'h0000_CAFE;
    #1;
    check_eq("stray_a_resp", 32'(bus.a_resp), 32'd0);
    check_eq("stray_b_resp", 32'(bus.b_resp), 32'd0);
    check_eq("stray_a_rdata", bus.a_rdata, 32'h0000_CAFE);
    check_eq("stray_b_rdata", bus.b_rdata, 32'h0000_CAFE);
    @(negedge clk);
    drop_all();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
